// File: rtl/dht22_sensor_responder.sv
// rtl/dht22_sensor_responder.sv - DHT22 sensor-side emulator for the single-wire protocol

module dht22_checksum (
    input  logic [15:0] humidity,
    input  logic [15:0] temperature,
    output logic [7:0]  checksum
);

    // Byte sum with the carry out of bit 7 dropped
    always_comb begin
        checksum = humidity[15:8] + humidity[7:0] + temperature[15:8] + temperature[7:0];
    end

endmodule

module dht22_sensor_responder #(
    parameter int TICKS_PER_US   = 100,
    parameter int T_START_MIN_US = 800,
    parameter int T_WAIT_US      = 30,
    parameter int T_RESP_LOW_US  = 80,
    parameter int T_RESP_HIGH_US = 80,
    parameter int T_BIT_LOW_US   = 50,
    parameter int T_BIT0_HIGH_US = 26,
    parameter int T_BIT1_HIGH_US = 70
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] humidity,
    input  logic [15:0] temperature,
    input  logic        dq_i,
    output logic        dq_oe,
    output logic        busy,
    output logic        frame_done,
    output logic        err
);

    localparam int TW = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_US - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOST_LOW,
        S_WAIT,
        S_RESP_LOW,
        S_RESP_HIGH,
        S_BIT_LOW,
        S_BIT_HIGH,
        S_END_LOW
    } state_t;

    state_t        state, state_n;
    logic          dq_meta, dq_s, dq_s_d;
    logic [TW-1:0] tick, tick_n;
    logic [15:0]   us, us_n;
    logic [1:0]    settle, settle_n;
    logic          low_seen, low_seen_n;
    logic [39:0]   frame, frame_n;
    logic [5:0]    bits_left, bits_left_n;
    logic          busy_n, done_n, err_n;
    logic [7:0]    checksum;
    logic [15:0]   phase_len;
    logic          us_tick, phase_end, release_phase, collision;

    dht22_checksum u_checksum (
        .humidity    (humidity),
        .temperature (temperature),
        .checksum    (checksum)
    );

    // Two-flop synchronizer plus one delayed copy for falling-edge detection
    always_ff @(posedge clock) begin
        if (reset) begin
            dq_meta <= 1'b1;
            dq_s    <= 1'b1;
            dq_s_d  <= 1'b1;
        end else begin
            dq_meta <= dq_i;
            dq_s    <= dq_meta;
            dq_s_d  <= dq_s;
        end
    end

    // Length in microseconds of the timed phase the FSM is currently in
    always_comb begin
        phase_len = 16'd0;
        case (state)
            S_WAIT:      phase_len = 16'(T_WAIT_US);
            S_RESP_LOW:  phase_len = 16'(T_RESP_LOW_US);
            S_RESP_HIGH: phase_len = 16'(T_RESP_HIGH_US);
            S_BIT_LOW:   phase_len = 16'(T_BIT_LOW_US);
            S_BIT_HIGH:  phase_len = frame[39] ? 16'(T_BIT1_HIGH_US) : 16'(T_BIT0_HIGH_US);
            S_END_LOW:   phase_len = 16'(T_BIT_LOW_US);
            default:     phase_len = 16'd0;
        endcase
    end

    // Phase timing and collision qualifiers; the first three cycles of a released
    // phase are ignored because the synchronizer still shows our own low drive
    always_comb begin
        us_tick       = (tick == TICK_LAST);
        phase_end     = us_tick && (us == phase_len - 16'd1);
        release_phase = (state == S_WAIT) || (state == S_RESP_HIGH) || (state == S_BIT_HIGH);
        collision     = release_phase && (settle == 2'd3) && !dq_s && low_seen;
    end

    // Next-state, datapath and output decode
    always_comb begin
        state_n     = state;
        tick_n      = us_tick ? '0 : tick + TW'(1);
        us_n        = (us_tick && (us != 16'hFFFF)) ? us + 16'd1 : us;
        settle_n    = (settle == 2'd3) ? settle : settle + 2'd1;
        low_seen_n  = (settle == 2'd3) && !dq_s;
        frame_n     = frame;
        bits_left_n = bits_left;
        busy_n      = busy;
        done_n      = 1'b0;
        err_n       = 1'b0;
        dq_oe       = (state == S_RESP_LOW) || (state == S_BIT_LOW) || (state == S_END_LOW);

        case (state)
            S_IDLE: begin
                if (enable && dq_s_d && !dq_s) state_n = S_HOST_LOW;
            end
            S_HOST_LOW: begin
                if (dq_s) begin
                    if (us >= 16'(T_START_MIN_US)) begin
                        frame_n     = {humidity, temperature, checksum};
                        bits_left_n = 6'd40;
                        busy_n      = 1'b1;
                        state_n     = S_WAIT;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            S_WAIT:      if (phase_end) state_n = S_RESP_LOW;
            S_RESP_LOW:  if (phase_end) state_n = S_RESP_HIGH;
            S_RESP_HIGH: if (phase_end) state_n = S_BIT_LOW;
            S_BIT_LOW:   if (phase_end) state_n = S_BIT_HIGH;
            S_BIT_HIGH: begin
                if (phase_end) begin
                    frame_n     = {frame[38:0], 1'b0};
                    bits_left_n = bits_left - 6'd1;
                    state_n     = (bits_left == 6'd1) ? S_END_LOW : S_BIT_LOW;
                end
            end
            S_END_LOW: begin
                if (phase_end) begin
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (collision) begin
            state_n = S_IDLE;
            err_n   = 1'b1;
            busy_n  = 1'b0;
            done_n  = 1'b0;
        end

        if (!enable) begin
            state_n = S_IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b0;
            err_n   = 1'b0;
        end

        // Every phase boundary is a state change, so timing restarts there
        if (state_n != state) begin
            tick_n     = '0;
            us_n       = 16'd0;
            settle_n   = 2'd0;
            low_seen_n = 1'b0;
        end
    end

    // State, counters and registered status outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            tick       <= '0;
            us         <= 16'd0;
            settle     <= 2'd0;
            low_seen   <= 1'b0;
            frame      <= 40'd0;
            bits_left  <= 6'd0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            tick       <= tick_n;
            us         <= us_n;
            settle     <= settle_n;
            low_seen   <= low_seen_n;
            frame      <= frame_n;
            bits_left  <= bits_left_n;
            busy       <= busy_n;
            frame_done <= done_n;
            err        <= err_n;
        end
    end

endmodule

// File: tb/tb_dht22_sensor_responder.sv
// tb/tb_dht22_sensor_responder.sv - Directed self-checking bench for dht22_sensor_responder

module tb_dht22_sensor_responder;

    localparam int T         = 10;
    localparam int START_MIN = 80;
    localparam int WAIT_US   = 3;
    localparam int RLOW_US   = 8;
    localparam int RHIGH_US  = 8;
    localparam int BLOW_US   = 5;
    localparam int B0_US     = 3;
    localparam int B1_US     = 7;
    localparam int LONG_US   = 100;
    localparam int SHORT_US  = 50;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] humidity = 16'h0000;
    logic [15:0] temperature = 16'h0000;
    logic        host_low = 1'b0;
    logic        dq_i;
    logic        dq_oe;
    logic        busy;
    logic        frame_done;
    logic        err;

    int          checks = 0;
    int          errors = 0;
    logic [39:0] exp_q[$];

    assign dq_i = !(dq_oe || host_low);

    always #5 clock = ~clock;

    dht22_sensor_responder #(
        .TICKS_PER_US   (T),
        .T_START_MIN_US (START_MIN),
        .T_WAIT_US      (WAIT_US),
        .T_RESP_LOW_US  (RLOW_US),
        .T_RESP_HIGH_US (RHIGH_US),
        .T_BIT_LOW_US   (BLOW_US),
        .T_BIT0_HIGH_US (B0_US),
        .T_BIT1_HIGH_US (B1_US)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .humidity    (humidity),
        .temperature (temperature),
        .dq_i        (dq_i),
        .dq_oe       (dq_oe),
        .busy        (busy),
        .frame_done  (frame_done),
        .err         (err)
    );

    task automatic check(input string tag, input logic [39:0] observed, input logic [39:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [39:0] frame_of(input logic [15:0] h, input logic [15:0] t);
        logic [7:0] cs;
        cs = h[15:8] + h[7:0] + t[15:8] + t[7:0];
        return {h, t, cs};
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic measure(input logic level, input int limit, output int n);
        n = 0;
        while (dq_oe === level && n < limit) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic host_start(input int low_us, input bit push, input logic [39:0] expected);
        @(negedge clock);
        host_low = 1'b1;
        cycles(low_us * T);
        host_low = 1'b0;
        if (push) exp_q.push_back(expected);
    endtask

    task automatic watch_silent(input string tag, input int n);
        bit saw_oe;
        bit saw_busy;
        saw_oe   = 1'b0;
        saw_busy = 1'b0;
        repeat (n) begin
            @(negedge clock);
            if (dq_oe !== 1'b0) saw_oe = 1'b1;
            if (busy !== 1'b0) saw_busy = 1'b1;
        end
        check({tag, "_no_oe"}, saw_oe, 0);
        check({tag, "_no_busy"}, saw_busy, 0);
    endtask

    task automatic receive_frame(input int abort_bit, input bit change_hum, input logic [15:0] new_hum);
        int          n;
        logic [39:0] got;
        logic [39:0] expected;
        bit          timing_ok;

        // sync (2) + state register (1) before the wait phase starts counting
        measure(1'b0, 400, n);
        check("wait_to_resp", n, 3 + WAIT_US * T);
        check("busy_in_resp", busy, 1);
        if (change_hum) humidity = new_hum;
        measure(1'b1, 2000, n);
        check("resp_low", n, RLOW_US * T);
        measure(1'b0, 2000, n);
        check("resp_high", n, RHIGH_US * T);

        timing_ok = 1'b1;
        got = 40'd0;
        for (int b = 0; b < 40; b++) begin
            measure(1'b1, 2000, n);
            if (n != BLOW_US * T) timing_ok = 1'b0;
            if (b == abort_bit) begin
                cycles(T);
                host_low = 1'b1;
                n = 0;
                while (err !== 1'b1 && n < 6) begin
                    @(negedge clock);
                    n++;
                end
                check("err_within_5", n <= 5, 1);
                check("abort_oe", dq_oe, 0);
                check("abort_busy", busy, 0);
                @(negedge clock);
                check("err_one_cycle", err, 0);
                cycles(2 * T);
                host_low = 1'b0;
                watch_silent("after_abort", 100);
                check("abort_no_done", frame_done, 0);
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                return;
            end
            measure(1'b0, 2000, n);
            if (n != B0_US * T && n != B1_US * T) timing_ok = 1'b0;
            got = {got[38:0], (n > ((B0_US + B1_US) * T) / 2)};
        end
        measure(1'b1, 2000, n);
        check("end_low", n, BLOW_US * T);
        check("bit_timing", timing_ok, 1);
        check("frame_done_pulse", frame_done, 1);
        check("busy_cleared", busy, 0);
        @(negedge clock);
        check("frame_done_single", frame_done, 0);

        if (exp_q.size() == 0) begin
            check("scoreboard_nonempty", 0, 1);
        end else begin
            expected = exp_q.pop_front();
            check("frame_bits", got, expected);
        end
    endtask

    initial begin
        cycles(5);
        check("reset_dq_oe", dq_oe, 0);
        check("reset_busy", busy, 0);
        check("reset_done", frame_done, 0);
        check("reset_err", err, 0);
        reset  = 1'b0;
        enable = 1'b1;
        cycles(5);

        // Test 1: basic frame
        humidity    = 16'h028C;
        temperature = 16'h015F;
        host_start(LONG_US, 1'b1, 40'h028C015FEE);
        receive_frame(-1, 1'b0, 16'h0000);
        cycles(20);

        // Test 2: negative temperature, checksum wraps
        temperature = 16'h8065;
        host_start(LONG_US, 1'b1, 40'h028C806573);
        receive_frame(-1, 1'b0, 16'h0000);
        cycles(20);

        // Test 3: short host pulse ignored, then a normal start
        host_start(SHORT_US, 1'b0, 40'd0);
        watch_silent("short_start", 200);
        temperature = 16'h015F;
        host_start(LONG_US, 1'b1, frame_of(16'h028C, 16'h015F));
        receive_frame(-1, 1'b0, 16'h0000);
        cycles(20);

        // Test 4: collision in the third bit-high phase, then recovery
        host_start(LONG_US, 1'b1, frame_of(16'h028C, 16'h015F));
        receive_frame(2, 1'b0, 16'h0000);
        humidity    = 16'h01F4;
        temperature = 16'h00C8;
        host_start(LONG_US, 1'b1, frame_of(16'h01F4, 16'h00C8));
        receive_frame(-1, 1'b0, 16'h0000);
        cycles(20);

        // Test 5: reset during response low
        host_start(LONG_US, 1'b1, frame_of(16'h01F4, 16'h00C8));
        begin
            int n;
            measure(1'b0, 400, n);
            check("resp_before_reset", dq_oe, 1);
        end
        cycles(2 * T);
        reset = 1'b1;
        @(negedge clock);
        check("reset_mid_oe", dq_oe, 0);
        check("reset_mid_busy", busy, 0);
        cycles(3);
        reset = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        cycles(10);
        humidity    = 16'hFFFF;
        temperature = 16'hFFFF;
        host_start(LONG_US, 1'b1, 40'hFFFFFFFFFC);
        receive_frame(-1, 1'b0, 16'h0000);
        cycles(20);

        // Test 6: disabled responder, then snapshot stability
        enable = 1'b0;
        host_start(LONG_US, 1'b0, 40'd0);
        watch_silent("disabled", 200);
        enable = 1'b1;
        cycles(5);
        humidity    = 16'h0123;
        temperature = 16'h0045;
        host_start(LONG_US, 1'b1, frame_of(16'h0123, 16'h0045));
        receive_frame(-1, 1'b1, 16'hABCD);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
